// File: rtl/rob_commit_ctrl_pkg.sv
// Shared types and sizing for the reorder-buffer commit sequencer.
// Imported by the interface, the entry store and the top.
package rob_commit_ctrl_pkg;

  localparam int DEPTH = 16;
  localparam int TAGW  = $clog2(DEPTH);
  localparam int XLEN  = 32;
  localparam int REGW  = 5;

  typedef logic [TAGW-1:0] tag_t;
  typedef logic [TAGW:0]   count_t;
  typedef logic [XLEN-1:0] xlen_t;
  typedef logic [REGW-1:0] reg_t;

  typedef struct packed {
    logic  busy;
    logic  ready;
    logic  isBr;
    logic  mispred;
    reg_t  rd;
    xlen_t val;
    xlen_t target;
  } rob_entry_t;

  function automatic tag_t nextTag(input tag_t t);
    return t + tag_t'(1);
  endfunction

endpackage

// File: rtl/rob_commit_ctrl_if.sv
// Dispatch, writeback and commit/rollback signals of the reorder buffer.
// master = dispatcher/execution side, slave = the reorder buffer itself.
interface rob_commit_ctrl_if;
  import rob_commit_ctrl_pkg::*;

  logic   alloc_valid;
  reg_t   alloc_rd;
  logic   alloc_is_br;
  tag_t   alloc_tag;
  logic   full;
  logic   rename_valid;

  logic   wb_valid;
  tag_t   wb_tag;
  xlen_t  wb_val;
  logic   wb_mispred;
  xlen_t  wb_target;

  logic   commit_valid;
  reg_t   commit_rd;
  tag_t   commit_tag;
  xlen_t  commit_val;
  logic   rollback;
  xlen_t  rollback_pc;
  count_t count;

  modport master (
    output alloc_valid, alloc_rd, alloc_is_br,
    output wb_valid, wb_tag, wb_val, wb_mispred, wb_target,
    input  alloc_tag, full, rename_valid,
    input  commit_valid, commit_rd, commit_tag, commit_val,
    input  rollback, rollback_pc, count
  );

  modport slave (
    input  alloc_valid, alloc_rd, alloc_is_br,
    input  wb_valid, wb_tag, wb_val, wb_mispred, wb_target,
    output alloc_tag, full, rename_valid,
    output commit_valid, commit_rd, commit_tag, commit_val,
    output rollback, rollback_pc, count
  );

endinterface

// File: rtl/rob_entry_store.sv
// Reorder-buffer entry array: one alloc write port, one writeback port,
// one head read port, plus a flush that clears every busy bit.
module rob_entry_store
  import rob_commit_ctrl_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  flush_i,
  input  logic  alloc_we_i,
  input  tag_t  alloc_idx_i,
  input  reg_t  alloc_rd_i,
  input  logic  alloc_is_br_i,
  input  logic  wb_we_i,
  input  tag_t  wb_idx_i,
  input  xlen_t wb_val_i,
  input  logic  wb_mispred_i,
  input  xlen_t wb_target_i,
  input  logic  retire_i,
  input  tag_t  head_idx_i,
  output logic  head_busy_o,
  output logic  head_ready_o,
  output logic  head_mispred_o,
  output reg_t  head_rd_o,
  output xlen_t head_val_o,
  output xlen_t head_target_o
);

  rob_entry_t entries_q [DEPTH];

  // Only a branch can mispredict, so a stray mispred flag on a plain op is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
    end else if (flush_i) begin
      for (int i = 0; i < DEPTH; i++) entries_q[i].busy <= 1'b0;
    end else begin
      if (alloc_we_i) begin
        entries_q[alloc_idx_i] <= '{busy: 1'b1, ready: 1'b0, isBr: alloc_is_br_i,
                                    mispred: 1'b0, rd: alloc_rd_i, val: '0, target: '0};
      end
      if (wb_we_i && entries_q[wb_idx_i].busy) begin
        entries_q[wb_idx_i].ready   <= 1'b1;
        entries_q[wb_idx_i].val     <= wb_val_i;
        entries_q[wb_idx_i].mispred <= wb_mispred_i & entries_q[wb_idx_i].isBr;
        entries_q[wb_idx_i].target  <= wb_target_i;
      end
      if (retire_i) entries_q[head_idx_i].busy <= 1'b0;
    end
  end

  assign head_busy_o    = entries_q[head_idx_i].busy;
  assign head_ready_o   = entries_q[head_idx_i].ready;
  assign head_mispred_o = entries_q[head_idx_i].mispred;
  assign head_rd_o      = entries_q[head_idx_i].rd;
  assign head_val_o     = entries_q[head_idx_i].val;
  assign head_target_o  = entries_q[head_idx_i].target;

endmodule

// File: rtl/rob_commit_ctrl.sv
// In-order commit sequencer: circular reorder buffer with per-cycle head retire
// and a full flush plus rollback pulse when a mispredicted branch reaches the head.
module rob_commit_ctrl
  import rob_commit_ctrl_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    rdy,
  rob_commit_ctrl_if.slave        rob
);

  tag_t   head_q, head_d, tail_q, tail_d;
  count_t count_q, count_d;
  logic   commit_valid_q, commit_valid_d;
  reg_t   commit_rd_q, commit_rd_d;
  tag_t   commit_tag_q, commit_tag_d;
  xlen_t  commit_val_q, commit_val_d;
  logic   rollback_q, rollback_d;
  xlen_t  rollback_pc_q, rollback_pc_d;

  logic   headBusy, headReady, headMispred;
  reg_t   headRd;
  xlen_t  headVal, headTarget;
  logic   full, headCommit, headFlush, allocFire;

  assign full       = (count_q == count_t'(DEPTH)) | rollback_q;
  assign headCommit = headBusy & headReady & ~headMispred;
  assign headFlush  = headBusy & headReady & headMispred;
  assign allocFire  = rdy & rob.alloc_valid & ~full & ~headFlush;

  rob_entry_store u_store (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush_i        (rdy & headFlush),
    .alloc_we_i     (allocFire),
    .alloc_idx_i    (tail_q),
    .alloc_rd_i     (rob.alloc_rd),
    .alloc_is_br_i  (rob.alloc_is_br),
    .wb_we_i        (rdy & rob.wb_valid & ~headFlush),
    .wb_idx_i       (rob.wb_tag),
    .wb_val_i       (rob.wb_val),
    .wb_mispred_i   (rob.wb_mispred),
    .wb_target_i    (rob.wb_target),
    .retire_i       (rdy & headCommit),
    .head_idx_i     (head_q),
    .head_busy_o    (headBusy),
    .head_ready_o   (headReady),
    .head_mispred_o (headMispred),
    .head_rd_o      (headRd),
    .head_val_o     (headVal),
    .head_target_o  (headTarget)
  );

  // The head decision looks only at registered entry state, so a writeback to
  // the head on the same edge is seen one cycle later.
  always_comb begin
    head_d         = head_q;
    tail_d         = tail_q;
    count_d        = count_q;
    commit_valid_d = commit_valid_q;
    commit_rd_d    = commit_rd_q;
    commit_tag_d   = commit_tag_q;
    commit_val_d   = commit_val_q;
    rollback_d     = rollback_q;
    rollback_pc_d  = rollback_pc_q;
    if (rdy) begin
      commit_valid_d = 1'b0;
      rollback_d     = 1'b0;
      if (headFlush) begin
        rollback_d    = 1'b1;
        rollback_pc_d = headTarget;
        head_d        = '0;
        tail_d        = '0;
        count_d       = '0;
      end else begin
        if (headCommit) begin
          commit_valid_d = 1'b1;
          commit_rd_d    = headRd;
          commit_tag_d   = head_q;
          commit_val_d   = headVal;
          head_d         = nextTag(head_q);
        end
        if (allocFire) tail_d = nextTag(tail_q);
        count_d = count_q + count_t'(allocFire) - count_t'(headCommit);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      commit_valid_q <= 1'b0;
      commit_rd_q    <= '0;
      commit_tag_q   <= '0;
      commit_val_q   <= '0;
      rollback_q     <= 1'b0;
      rollback_pc_q  <= '0;
    end else begin
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      commit_valid_q <= commit_valid_d;
      commit_rd_q    <= commit_rd_d;
      commit_tag_q   <= commit_tag_d;
      commit_val_q   <= commit_val_d;
      rollback_q     <= rollback_d;
      rollback_pc_q  <= rollback_pc_d;
    end
  end

  assign rob.alloc_tag    = tail_q;
  assign rob.full         = full;
  assign rob.rename_valid = rdy & rob.alloc_valid & ~full;
  assign rob.count        = count_q;
  assign rob.commit_valid = commit_valid_q;
  assign rob.commit_rd    = commit_rd_q;
  assign rob.commit_tag   = commit_tag_q;
  assign rob.commit_val   = commit_val_q;
  assign rob.rollback     = rollback_q;
  assign rob.rollback_pc  = rollback_pc_q;

endmodule
